// File: rtl/compressor_mc.sv
// Multi-channel 66b->65b block compressor for the FEC encoder input stage.
// Two-stage pipeline: input capture, then header fold / bit order / codeword index.
module compressor_mc #(
  parameter int NUM_CH     = 1,
  parameter int BLK_PER_CW = 32,
  parameter int REVERSE    = 1,
  localparam int CW        = $clog2(BLK_PER_CW)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   ENA,
  input  logic [66*NUM_CH-1:0]   PCS_BLK,
  input  logic                   ALIGN,
  input  logic                   CLR_CNT,
  output logic [65*NUM_CH-1:0]   T_BLK,
  output logic                   T_BLK_ENA,
  output logic [CW-1:0]          BLK_CNT,
  output logic                   CW_START,
  output logic [NUM_CH-1:0]      SH_ERR,
  output logic [15:0]            SH_ERR_CNT
);

  logic [66*NUM_CH-1:0] blk_s;
  logic                 ena_s;
  logic                 align_s;
  logic [65*NUM_CH-1:0] t_c;
  logic [NUM_CH-1:0]    err_c;
  logic [CW-1:0]        nxt;
  logic [CW-1:0]        idx;
  logic [CW-1:0]        nxt_n;

  always_comb begin : p_compress
    logic [65:0] b;
    logic [64:0] t;
    b     = '0;
    t     = '0;
    t_c   = '0;
    err_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      b        = blk_s[66*c +: 66];
      // Sync header folds to one bit: sh[1] xor data[8].
      t        = {b[65:2], b[1] ^ b[10]};
      err_c[c] = (b[1:0] == 2'b00) || (b[1:0] == 2'b11);
      for (int unsigned i = 0; i < 65; i++) begin
        t_c[65*c + i] = (REVERSE != 0) ? t[64 - i] : t[i];
      end
    end
  end

  // Wrap by compare so non-power-of-2 codeword lengths work.
  always_comb begin
    idx   = align_s ? '0 : nxt;
    nxt_n = (idx == CW'(BLK_PER_CW - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      blk_s      <= '0;
      ena_s      <= 1'b0;
      align_s    <= 1'b0;
      T_BLK      <= '0;
      T_BLK_ENA  <= 1'b0;
      SH_ERR     <= '0;
      BLK_CNT    <= '0;
      nxt        <= '0;
      SH_ERR_CNT <= '0;
    end else begin
      blk_s     <= PCS_BLK;
      ena_s     <= ENA;
      align_s   <= ALIGN;
      T_BLK     <= t_c;
      T_BLK_ENA <= ena_s;
      SH_ERR    <= ena_s ? err_c : '0;
      if (ena_s) begin
        BLK_CNT <= idx;
        nxt     <= nxt_n;
      end
      if (CLR_CNT) begin
        SH_ERR_CNT <= '0;
      end else if (ena_s && (|err_c) && (SH_ERR_CNT != '1)) begin
        SH_ERR_CNT <= SH_ERR_CNT + 16'd1;
      end
    end
  end

  assign CW_START = T_BLK_ENA && (BLK_CNT == '0);

endmodule
